// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, instruction
// field positions and default PC parameters.
package ifu_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_WAIT  = 2'd2
   } ifu_state_e;

   localparam int OPC_MSB   = 31;
   localparam int OPC_W     = 6;
   localparam int RS_MSB    = 25;
   localparam int RS_W      = 5;
   localparam int RT_MSB    = 20;
   localparam int RT_W      = 5;
   localparam int IMM_MSB   = 15;
   localparam int IMM_W     = 16;
   localparam int FUNCT_MSB = 4;
   localparam int FUNCT_W   = 5;
   // Label offsets use the whole low 26 bits of the instruction word.
   localparam int LBL_MSB   = 25;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC selection: jump_to_reg > label > taken branch > sequential.
// All arithmetic wraps modulo 2^32; unaligned targets pass through untouched.
module next_pc_calc
   import ifu_pkg::*;
#(
   parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
)(
   input  logic [31:0]      i_pc,
   input  logic [LBL_MSB:0] i_offs,
   input  logic             i_branch,
   input  logic             i_branch_cond,
   input  logic             i_jump_to_reg,
   input  logic             i_label,
   input  logic [31:0]      i_reg_target,
   output logic [31:0]      o_next_pc
);

   logic [31:0] w_pc4;
   logic [31:0] w_label_off;
   logic [31:0] w_branch_off;

   assign w_pc4        = i_pc + PC_STEP;
   assign w_label_off  = {{4{i_offs[LBL_MSB]}}, i_offs, 2'b00};
   assign w_branch_off = {{14{i_offs[IMM_MSB]}}, i_offs[IMM_MSB:0], 2'b00};

   always_comb begin
      o_next_pc = w_pc4;
      if (i_jump_to_reg) begin
         o_next_pc = i_reg_target;
      end else if (i_label) begin
         o_next_pc = w_pc4 + w_label_off;
      end else if (i_branch && i_branch_cond) begin
         o_next_pc = w_pc4 + w_branch_off;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: FETCH -> HOLD -> WAIT loop that requests a word from a variable
// latency memory, presents its decoded fields, then steps the PC on exec_done.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [15:0] imm,
   output logic [4:0]  funct,
   input  logic        exec_done,
   input  logic        branch,
   input  logic        branch_cond,
   input  logic        jump_to_reg,
   input  logic        label,
   input  logic [31:0] reg_target
);

   ifu_state_e  r_state;
   ifu_state_e  w_state_next;
   logic        r_active;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_pc_out;
   logic [31:0] w_next_pc;
   logic        w_fetch_accept;
   logic        w_exec_accept;

   // r_active is low for the reset cycles and the first cycle after release, so the
   // request only rises once reset is gone and any late imem_ready is discarded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_FETCH;
         r_active <= 1'b0;
         r_pc     <= RESET_PC;
         r_ir     <= 32'd0;
         r_pc_out <= 32'd0;
      end else begin
         r_state  <= w_state_next;
         r_active <= 1'b1;
         if (w_fetch_accept) begin
            r_ir     <= imem_rdata;
            r_pc_out <= r_pc;
         end
         if (w_exec_accept) begin
            r_pc <= w_next_pc;
         end
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_fetch_accept = 1'b0;
      w_exec_accept  = 1'b0;
      unique case (r_state)
         ST_FETCH: begin
            if (r_active && imem_ready) begin
               w_fetch_accept = 1'b1;
               w_state_next   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (exec_done) begin
               w_exec_accept = 1'b1;
               w_state_next  = ST_WAIT;
            end
         end
         ST_WAIT: w_state_next = ST_FETCH;
         default: w_state_next = ST_FETCH;
      endcase
   end

   next_pc_calc #(
      .PC_STEP (PC_STEP)
   ) u_next_pc (
      .i_pc          (r_pc),
      .i_offs        (r_ir[LBL_MSB:0]),
      .i_branch      (branch),
      .i_branch_cond (branch_cond),
      .i_jump_to_reg (jump_to_reg),
      .i_label       (label),
      .i_reg_target  (reg_target),
      .o_next_pc     (w_next_pc)
   );

   assign imem_req    = r_active && (r_state == ST_FETCH);
   assign imem_addr   = r_pc;
   assign instr_valid = (r_state == ST_HOLD);
   assign pc_out      = r_pc_out;
   assign opcode      = r_ir[OPC_MSB   -: OPC_W];
   assign rs          = r_ir[RS_MSB    -: RS_W];
   assign rt          = r_ir[RT_MSB    -: RT_W];
   assign imm         = r_ir[IMM_MSB   -: IMM_W];
   assign funct       = r_ir[FUNCT_MSB -: FUNCT_W];

endmodule
